prom_fetch_arbiter: RTL and testbench

Sequencer and arbiter for the single-port program ROM (promdata: 16-bit address in, 32-bit data out, combinational read). It shares the ROM between two requesters:
- the CPU instruction stream, served through a small prefetch FIFO;
- a data-read port used for constant/table loads.

It issues at most one ROM access per clock, handles PC redirects by flushing the FIFO, and arbitrates so that neither requester starves.

---
 rtl/prom_fetch_arbiter.sv | 106 ++++++++++
 tb/tb_prom_fetch_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prom_fetch_arbiter.sv
// Shares the single-port program ROM between a prefetching instruction stream
// and a data-read port, one access per clock, with PC redirect flushing.
module prom_fetch_arbiter #(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [15:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        pc_load,
    input  logic [15:0] pc_value,
    output logic        instr_valid,
    output logic [31:0] instr_data,
    output logic [15:0] instr_addr,
    input  logic        instr_ready,
    input  logic        rd_req,
    input  logic [15:0] rd_addr,
    output logic        rd_ack,
    output logic [31:0] rd_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {G_IDLE, G_FETCH, G_DATA} grant_e;

    logic [15:0]   fetch_pc_q;
    logic [15:0]   mem_addr_q [DEPTH];
    logic [31:0]   mem_data_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, occ;
    logic          last_data_q, rd_ack_q;
    logic [31:0]   rd_data_q, hold_data_q;
    logic [15:0]   hold_addr_q;
    grant_e        grant;
    logic          pop, push, fetch_want, data_want;

    // Slot arbitration: data wins ties unless the FIFO is dry and data had the last slot.
    always_comb begin
        pop        = instr_valid && instr_ready;
        occ        = count_q - CW'(pop);
        fetch_want = !pc_load && (int'(occ) < DEPTH);
        data_want  = rd_req && !rd_ack_q;
        grant      = G_IDLE;
        if (data_want && fetch_want)
            grant = (count_q == '0 && last_data_q) ? G_FETCH : G_DATA;
        else if (data_want)
            grant = G_DATA;
        else if (fetch_want)
            grant = G_FETCH;
        push = (grant == G_FETCH);
    end

    assign rom_addr    = (grant == G_DATA) ? rd_addr : fetch_pc_q;
    assign instr_valid = (count_q != '0);
    assign instr_data  = instr_valid ? mem_data_q[rd_ptr_q] : hold_data_q;
    assign instr_addr  = instr_valid ? mem_addr_q[rd_ptr_q] : hold_addr_q;
    // A read whose ack cycle coincides with reset is dropped.
    assign rd_ack      = rd_ack_q && !RST;
    assign rd_data     = rd_data_q;

    always_ff @(posedge CLK) begin
        if (!RST && push) begin
            mem_addr_q[wr_ptr_q] <= fetch_pc_q;
            mem_data_q[wr_ptr_q] <= rom_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_pc_q  <= RESET_PC;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_data_q <= 1'b0;
            rd_ack_q    <= 1'b0;
            rd_data_q   <= '0;
            hold_data_q <= '0;
            hold_addr_q <= '0;
        end else begin
            rd_ack_q <= (grant == G_DATA);
            if (grant == G_DATA)
                rd_data_q <= rom_data;
            if (grant != G_IDLE)
                last_data_q <= (grant == G_DATA);
            if (instr_valid) begin
                hold_data_q <= mem_data_q[rd_ptr_q];
                hold_addr_q <= mem_addr_q[rd_ptr_q];
            end
            if (pc_load) begin
                fetch_pc_q <= pc_value;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q   <= wr_ptr_q + AW'(1);
                    fetch_pc_q <= fetch_pc_q + 16'd1;
                end
                if (pop)
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_prom_fetch_arbiter.sv
// Directed bench for prom_fetch_arbiter (DEPTH=2) with a small combinational ROM model.
module tb_prom_fetch_arbiter;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] rom_addr;
    logic [31:0] rom_data;
    logic        pc_load = 1'b0;
    logic [15:0] pc_value = 16'h0;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [15:0] instr_addr;
    logic        instr_ready = 1'b0;
    logic        rd_req = 1'b0;
    logic [15:0] rd_addr = 16'h0;
    logic        rd_ack;
    logic [31:0] rd_data;

    int tests = 0;
    int fails = 0;

    prom_fetch_arbiter #(.DEPTH(2), .RESET_PC(16'h0000)) dut (
        .CLK(CLK), .RST(RST), .rom_addr(rom_addr), .rom_data(rom_data),
        .pc_load(pc_load), .pc_value(pc_value), .instr_valid(instr_valid),
        .instr_data(instr_data), .instr_addr(instr_addr), .instr_ready(instr_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] rom(input logic [15:0] a);
        case (a)
            16'h0000: rom = 32'h00080007;
            16'h0001: rom = 32'h04000008;
            16'h0002: rom = 32'h00002005;
            16'h0009: rom = 32'h00030008;
            16'h000C: rom = 32'h00080050;
            default:  rom = {16'hA5A5, a};
        endcase
    endfunction

    always_comb rom_data = rom(rom_addr);

    task automatic step();
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; pc_load = 1'b0; rd_req = 1'b0; instr_ready = 1'b0;
        step(); step();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge CLK);
        tests++;
        if (instr_valid !== 1'b0 || instr_data !== 32'h0 || instr_addr !== 16'h0) begin
            fails++; $display("FAIL reset_instr: got v=%b d=%h a=%h want 0/0/0", instr_valid, instr_data, instr_addr);
        end
        tests++;
        if (rd_ack !== 1'b0 || rd_data !== 32'h0 || rom_addr !== 16'h0) begin
            fails++; $display("FAIL reset_rd: got ack=%b data=%h rom_addr=%h want 0/0/0", rd_ack, rd_data, rom_addr);
        end
        step();
    endtask

    task automatic test_stream();
        logic [31:0] exp [3];
        exp = '{32'h00080007, 32'h04000008, 32'h00002005};
        do_reset();
        RST = 1'b0; instr_ready = 1'b1;
        @(negedge CLK);
        tests++;
        if (instr_valid !== 1'b0 || rom_addr !== 16'h0000) begin
            fails++; $display("FAIL stream_first: got v=%b rom_addr=%h want 0/0000", instr_valid, rom_addr);
        end
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            tests++;
            if (instr_valid !== 1'b1 || instr_addr !== 16'(i) || instr_data !== exp[i]) begin
                fails++; $display("FAIL stream_head%0d: got v=%b a=%h d=%h want 1/%h/%h", i, instr_valid, instr_addr, instr_data, 16'(i), exp[i]);
            end
            step();
        end
    endtask

    // Leaves the FIFO full with instr_ready low, fetch_pc=5, head at 0x0003.
    task automatic test_backpressure();
        logic [31:0] exp [3];
        exp = '{32'h00080007, 32'h04000008, 32'h00002005};
        do_reset();
        RST = 1'b0; instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (i == 2 || i == 9) begin
                tests++;
                if (rom_addr !== 16'h0002 || instr_valid !== 1'b1 || instr_addr !== 16'h0000) begin
                    fails++; $display("FAIL bp_stall%0d: got rom_addr=%h v=%b a=%h want 0002/1/0000", i, rom_addr, instr_valid, instr_addr);
                end
            end
            step();
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            tests++;
            if (instr_valid !== 1'b1 || instr_addr !== 16'(i) || instr_data !== exp[i]) begin
                fails++; $display("FAIL bp_resume%0d: got v=%b a=%h d=%h want 1/%h/%h", i, instr_valid, instr_addr, instr_data, 16'(i), exp[i]);
            end
            step();
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_data_read();
        rd_req = 1'b1; rd_addr = 16'h000C;
        @(negedge CLK);
        tests++;
        if (rom_addr !== 16'h000C || rd_ack !== 1'b0) begin
            fails++; $display("FAIL rd_grant: got rom_addr=%h ack=%b want 000c/0", rom_addr, rd_ack);
        end
        step();
        @(negedge CLK);
        tests++;
        if (rd_ack !== 1'b1 || rd_data !== 32'h00080050) begin
            fails++; $display("FAIL rd_ack: got ack=%b data=%h want 1/00080050", rd_ack, rd_data);
        end
        step();
        rd_req = 1'b0;
        @(negedge CLK);
        tests++;
        if (rd_ack !== 1'b0 || rd_data !== 32'h00080050 || rom_addr !== 16'h0005) begin
            fails++; $display("FAIL rd_single: got ack=%b data=%h rom_addr=%h want 0/00080050/0005", rd_ack, rd_data, rom_addr);
        end
        step();
    endtask

    task automatic test_alternate();
        logic [15:0] exp_addr;
        do_reset();
        RST = 1'b0; instr_ready = 1'b1; rd_req = 1'b1; rd_addr = 16'h000C;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            exp_addr = (i % 2 == 0) ? 16'h000C : 16'(i / 2);
            tests++;
            if (rom_addr !== exp_addr || rd_ack !== (i % 2 == 1)) begin
                fails++; $display("FAIL alt_grant%0d: got rom_addr=%h ack=%b want %h/%b", i, rom_addr, rd_ack, exp_addr, (i % 2 == 1));
            end
            if (i == 2 || i == 4) begin
                tests++;
                if (instr_valid !== 1'b1 || instr_addr !== 16'(i / 2 - 1)) begin
                    fails++; $display("FAIL alt_head%0d: got v=%b a=%h want 1/%h", i, instr_valid, instr_addr, 16'(i / 2 - 1));
                end
            end
            step();
        end
        rd_req = 1'b0;
    endtask

    task automatic test_starve_rule();
        do_reset();
        RST = 1'b0; instr_ready = 1'b1; rd_req = 1'b1; rd_addr = 16'h000C;
        step();
        pc_load = 1'b1; pc_value = 16'h0009;
        @(negedge CLK);
        tests++;
        if (rd_ack !== 1'b1 || rom_addr !== 16'h0000) begin
            fails++; $display("FAIL starve_idle: got ack=%b rom_addr=%h want 1/0000", rd_ack, rom_addr);
        end
        step();
        pc_load = 1'b0;
        @(negedge CLK);
        tests++;
        if (rom_addr !== 16'h0009 || instr_valid !== 1'b0) begin
            fails++; $display("FAIL starve_fetch_wins: got rom_addr=%h v=%b want 0009/0", rom_addr, instr_valid);
        end
        step();
        rd_req = 1'b0;
        @(negedge CLK);
        tests++;
        if (instr_valid !== 1'b1 || instr_addr !== 16'h0009 || instr_data !== 32'h00030008) begin
            fails++; $display("FAIL starve_head: got v=%b a=%h d=%h want 1/0009/00030008", instr_valid, instr_addr, instr_data);
        end
        step();
    endtask

    task automatic test_redirect();
        do_reset();
        RST = 1'b0; instr_ready = 1'b0;
        step(); step(); step();
        pc_load = 1'b1; pc_value = 16'h0009; rd_req = 1'b1; rd_addr = 16'h000C;
        @(negedge CLK);
        tests++;
        if (rom_addr !== 16'h000C) begin
            fails++; $display("FAIL redir_data_grant: got rom_addr=%h want 000c", rom_addr);
        end
        step();
        pc_load = 1'b0;
        @(negedge CLK);
        tests++;
        if (rd_ack !== 1'b1 || rd_data !== 32'h00080050 || rom_addr !== 16'h0009) begin
            fails++; $display("FAIL redir_ack: got ack=%b data=%h rom_addr=%h want 1/00080050/0009", rd_ack, rd_data, rom_addr);
        end
        tests++;
        if (instr_valid !== 1'b0 || instr_addr !== 16'h0000 || instr_data !== 32'h00080007) begin
            fails++; $display("FAIL redir_flush_hold: got v=%b a=%h d=%h want 0/0000/00080007", instr_valid, instr_addr, instr_data);
        end
        step();
        rd_req = 1'b0;
        @(negedge CLK);
        tests++;
        if (instr_valid !== 1'b1 || instr_addr !== 16'h0009 || instr_data !== 32'h00030008) begin
            fails++; $display("FAIL redir_head: got v=%b a=%h d=%h want 1/0009/00030008", instr_valid, instr_addr, instr_data);
        end
        step();
        // Back-to-back redirects: the second target wins.
        pc_load = 1'b1; pc_value = 16'h0005;
        step();
        pc_value = 16'h0007;
        step();
        pc_load = 1'b0;
        @(negedge CLK);
        tests++;
        if (instr_valid !== 1'b0 || rom_addr !== 16'h0007) begin
            fails++; $display("FAIL b2b_fetch: got v=%b rom_addr=%h want 0/0007", instr_valid, rom_addr);
        end
        step();
        @(negedge CLK);
        tests++;
        if (instr_valid !== 1'b1 || instr_addr !== 16'h0007 || instr_data !== 32'hA5A50007) begin
            fails++; $display("FAIL b2b_head: got v=%b a=%h d=%h want 1/0007/a5a50007", instr_valid, instr_addr, instr_data);
        end
        step();
        // Redirect to the top of the address space and watch it wrap.
        instr_ready = 1'b1; pc_load = 1'b1; pc_value = 16'hFFFF;
        step();
        pc_load = 1'b0;
        @(negedge CLK);
        tests++;
        if (instr_valid !== 1'b0 || rom_addr !== 16'hFFFF) begin
            fails++; $display("FAIL wrap_fetch: got v=%b rom_addr=%h want 0/ffff", instr_valid, rom_addr);
        end
        step();
        @(negedge CLK);
        tests++;
        if (instr_valid !== 1'b1 || instr_addr !== 16'hFFFF || instr_data !== 32'hA5A5FFFF) begin
            fails++; $display("FAIL wrap_head0: got v=%b a=%h d=%h want 1/ffff/a5a5ffff", instr_valid, instr_addr, instr_data);
        end
        step();
        @(negedge CLK);
        tests++;
        if (instr_valid !== 1'b1 || instr_addr !== 16'h0000 || instr_data !== 32'h00080007) begin
            fails++; $display("FAIL wrap_head1: got v=%b a=%h d=%h want 1/0000/00080007", instr_valid, instr_addr, instr_data);
        end
        step();
        instr_ready = 1'b0;
    endtask

    task automatic test_reset_midaccess();
        do_reset();
        RST = 1'b0; instr_ready = 1'b0;
        step(); step(); step();
        rd_req = 1'b1; rd_addr = 16'h000C;
        @(negedge CLK);
        tests++;
        if (rom_addr !== 16'h000C) begin
            fails++; $display("FAIL rst_mid_grant: got rom_addr=%h want 000c", rom_addr);
        end
        step();
        RST = 1'b1;
        @(negedge CLK);
        tests++;
        if (rd_ack !== 1'b0) begin
            fails++; $display("FAIL rst_mid_noack: got ack=%b want 0", rd_ack);
        end
        step();
        RST = 1'b0; rd_req = 1'b0;
        @(negedge CLK);
        tests++;
        if (instr_valid !== 1'b0 || rd_data !== 32'h0 || rd_ack !== 1'b0 || rom_addr !== 16'h0000) begin
            fails++; $display("FAIL rst_mid_state: got v=%b data=%h ack=%b rom_addr=%h want 0/0/0/0000", instr_valid, rd_data, rd_ack, rom_addr);
        end
        step();
        @(negedge CLK);
        tests++;
        if (instr_valid !== 1'b1 || instr_addr !== 16'h0000 || instr_data !== 32'h00080007) begin
            fails++; $display("FAIL rst_mid_restart: got v=%b a=%h d=%h want 1/0000/00080007", instr_valid, instr_addr, instr_data);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_data_read();
        test_alternate();
        test_starve_rule();
        test_redirect();
        test_reset_midaccess();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
